// File: rtl/qpu_exu_moitf_pkg.sv
// Shared sizing constants for the QPU measurement outstanding-instruction FIFO.
package qpu_exu_moitf_pkg;

    // Number of physical qubits handled by the execution unit.
    localparam int unsigned QPU_QUBIT_NUM = 12;

    // Outstanding measure entries; must be a power of two and at least 2.
    localparam int unsigned MOITF_DEPTH = 4;

    // log2(MOITF_DEPTH); pointers carry one extra wrap bit on top of this.
    localparam int unsigned MOITF_PTR_W = 2;

endpackage : qpu_exu_moitf_pkg

// File: rtl/qpu_exu_moitf_if.sv
// Dispatch and measurement-return signals of the MOITF, bundled for port hookup.
interface qpu_exu_moitf_if #(
    parameter int unsigned QUBIT_NUM = qpu_exu_moitf_pkg::QPU_QUBIT_NUM,
    parameter int unsigned PTR_W     = qpu_exu_moitf_pkg::MOITF_PTR_W
);

    // Dispatch side
    logic                 disp_moitf_ena;
    logic                 disp_moitf_ready;
    logic [QUBIT_NUM-1:0] disp_oitf_qubitlist;
    logic                 disp_oitf_qfren;
    logic                 oitfqf_match_dispql;

    // Measurement-result return side
    logic                 mres_i_valid;
    logic [QUBIT_NUM-1:0] mres_i_qubits;

    // Status
    logic [QUBIT_NUM-1:0] moitf_qflag;
    logic                 moitf_empty;
    logic [PTR_W:0]       moitf_cnt;
    logic                 moitf_err;

    // Dispatch stage / result path view
    modport master (
        output disp_moitf_ena,
        output disp_oitf_qubitlist,
        output disp_oitf_qfren,
        output mres_i_valid,
        output mres_i_qubits,
        input  disp_moitf_ready,
        input  oitfqf_match_dispql,
        input  moitf_qflag,
        input  moitf_empty,
        input  moitf_cnt,
        input  moitf_err
    );

    // MOITF view
    modport slave (
        input  disp_moitf_ena,
        input  disp_oitf_qubitlist,
        input  disp_oitf_qfren,
        input  mres_i_valid,
        input  mres_i_qubits,
        output disp_moitf_ready,
        output oitfqf_match_dispql,
        output moitf_qflag,
        output moitf_empty,
        output moitf_cnt,
        output moitf_err
    );

endinterface : qpu_exu_moitf_if

// File: rtl/qpu_fifo_ptr.sv
// Wrap-bit read/write pointer pair producing full/empty/occupancy for a 2^PTR_W FIFO.
// Callers qualify push/pop themselves (push only when not full, pop only when not empty).
module qpu_fifo_ptr #(
    parameter int unsigned PTR_W = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic             pop_i,
    output logic [PTR_W-1:0] widx_o,
    output logic [PTR_W-1:0] ridx_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [PTR_W:0]   cnt_o
);

    logic [PTR_W:0] wptr_q, wptr_d;
    logic [PTR_W:0] rptr_q, rptr_d;

    // Step each pointer on its strobe; index overflow toggles the wrap bit for free.
    always_comb begin
        wptr_d = wptr_q + {{PTR_W{1'b0}}, push_i};
        rptr_d = rptr_q + {{PTR_W{1'b0}}, pop_i};
    end

    // Pointer registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

    assign widx_o  = wptr_q[PTR_W-1:0];
    assign ridx_o  = rptr_q[PTR_W-1:0];
    assign empty_o = (wptr_q == rptr_q);
    assign full_o  = (wptr_q[PTR_W] != rptr_q[PTR_W]) &&
                     (wptr_q[PTR_W-1:0] == rptr_q[PTR_W-1:0]);
    assign cnt_o   = wptr_q - rptr_q;

endmodule : qpu_fifo_ptr

// File: rtl/qpu_exu_moitf.sv
// Measurement outstanding-instruction tracking FIFO: one entry per dispatched measure,
// holding the qubits still awaiting a result. Entries retire in order once fully resolved.
module qpu_exu_moitf #(
    parameter int unsigned QUBIT_NUM = qpu_exu_moitf_pkg::QPU_QUBIT_NUM,
    parameter int unsigned DEPTH     = qpu_exu_moitf_pkg::MOITF_DEPTH,
    parameter int unsigned PTR_W     = qpu_exu_moitf_pkg::MOITF_PTR_W
) (
    input  logic            clk,
    input  logic            rst,
    qpu_exu_moitf_if.slave  bus
);

    import qpu_exu_moitf_pkg::*;

    logic [PTR_W-1:0]     widx, ridx;
    logic                 full, empty;
    logic [PTR_W:0]       cnt;
    logic                 push, pop;

    logic [DEPTH-1:0]     valid_q, valid_d;
    logic [QUBIT_NUM-1:0] mask_q [DEPTH];
    logic [QUBIT_NUM-1:0] mask_d [DEPTH];

    logic [QUBIT_NUM-1:0] qflag;
    logic [QUBIT_NUM-1:0] clr_mask;
    logic [QUBIT_NUM-1:0] head_mask_post;
    logic                 err_q, err_d;

    qpu_fifo_ptr #(
        .PTR_W (PTR_W)
    ) u_ptr (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push),
        .pop_i   (pop),
        .widx_o  (widx),
        .ridx_o  (ridx),
        .full_o  (full),
        .empty_o (empty),
        .cnt_o   (cnt)
    );

    // Pending-qubit flags: OR of the masks of all live entries.
    always_comb begin
        qflag = '0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            if (valid_q[i]) begin
                qflag = qflag | mask_q[i];
            end
        end
    end

    // Allocate/retire decisions; the head is judged on its mask after this cycle's clear.
    always_comb begin
        clr_mask       = bus.mres_i_valid ? bus.mres_i_qubits : '0;
        push           = bus.disp_moitf_ena & ~full;
        head_mask_post = mask_q[ridx] & ~clr_mask;
        pop            = valid_q[ridx] & (head_mask_post == '0);
    end

    // Entry next-state: clear returned qubits everywhere, drop the head, then write the new entry.
    always_comb begin
        valid_d = valid_q;
        for (int i = 0; i < int'(DEPTH); i++) begin
            mask_d[i] = mask_q[i] & ~clr_mask;
        end
        if (pop) begin
            valid_d[ridx] = 1'b0;
        end
        if (push) begin
            valid_d[widx] = 1'b1;
            mask_d[widx]  = bus.disp_oitf_qubitlist;
        end
    end

    // Protocol errors: allocate while full, or a result for a qubit that is not pending.
    always_comb begin
        err_d = (bus.disp_moitf_ena & full) |
                (bus.mres_i_valid & (|(bus.mres_i_qubits & ~qflag)));
    end

    // Entry storage and error pulse register.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
            err_q   <= 1'b0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mask_q[i] <= '0;
            end
        end else begin
            valid_q <= valid_d;
            err_q   <= err_d;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mask_q[i] <= mask_d[i];
            end
        end
    end

    // Outputs are forced to their idle values while reset is held.
    assign bus.disp_moitf_ready    = rst | ~full;
    assign bus.moitf_empty         = rst | empty;
    assign bus.moitf_cnt           = rst ? '0 : cnt;
    assign bus.moitf_qflag         = rst ? '0 : qflag;
    assign bus.oitfqf_match_dispql = ~rst & bus.disp_oitf_qfren &
                                     (|(bus.disp_oitf_qubitlist & qflag));
    assign bus.moitf_err           = ~rst & err_q;

endmodule : qpu_exu_moitf

// File: tb/tb_qpu_exu_moitf.sv
// Self-checking bench for qpu_exu_moitf: a table of per-cycle vectors plus a hand-built
// full/retire corner sequence. Expected outputs are queued when inputs are driven and
// popped when the outputs are sampled.
module tb_qpu_exu_moitf;

    logic clk;
    logic rst;

    qpu_exu_moitf_if bus ();

    qpu_exu_moitf u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic        rst;
        logic        ena;
        logic [11:0] list;
        logic        qfren;
        logic        mv;
        logic [11:0] mq;
        logic        ready;
        logic        empty;
        logic [2:0]  cnt;
        logic [11:0] qflag;
        logic        match;
        logic        err;
    } vec_t;

    typedef struct packed {
        logic        ready;
        logic        empty;
        logic [2:0]  cnt;
        logic [11:0] qflag;
        logic        match;
        logic        err;
    } exp_t;

    vec_t tbl[$];
    exp_t sb[$];
    int   n_checks;
    int   n_fail;

    function automatic vec_t mk(input logic r, input logic e, input logic [11:0] l,
                                input logic qf, input logic mv, input logic [11:0] mq,
                                input logic rdy, input logic emp, input logic [2:0] c,
                                input logic [11:0] qfl, input logic m, input logic er);
        vec_t v;
        v.rst = r;   v.ena = e;    v.list = l;  v.qfren = qf;  v.mv = mv;    v.mq = mq;
        v.ready = rdy; v.empty = emp; v.cnt = c; v.qflag = qfl; v.match = m; v.err = er;
        return v;
    endfunction

    task automatic chk(input string name, input logic [11:0] act, input logic [11:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic check_out(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s scoreboard_empty actual=0 required=1", tag);
        end else begin
            e = sb.pop_front();
            chk({tag, ".ready"}, {11'd0, bus.disp_moitf_ready}, {11'd0, e.ready});
            chk({tag, ".empty"}, {11'd0, bus.moitf_empty}, {11'd0, e.empty});
            chk({tag, ".cnt"},   {9'd0, bus.moitf_cnt}, {9'd0, e.cnt});
            chk({tag, ".qflag"}, bus.moitf_qflag, e.qflag);
            chk({tag, ".match"}, {11'd0, bus.oitfqf_match_dispql}, {11'd0, e.match});
            chk({tag, ".err"},   {11'd0, bus.moitf_err}, {11'd0, e.err});
        end
    endtask

    // Drive one cycle's inputs at the falling edge, queue expectations, sample mid low phase.
    task automatic apply(input vec_t t, input string tag);
        exp_t e;
        @(negedge clk);
        rst                     = t.rst;
        bus.disp_moitf_ena      = t.ena;
        bus.disp_oitf_qubitlist = t.list;
        bus.disp_oitf_qfren     = t.qfren;
        bus.mres_i_valid        = t.mv;
        bus.mres_i_qubits       = t.mq;
        e.ready = t.ready; e.empty = t.empty; e.cnt = t.cnt;
        e.qflag = t.qflag; e.match = t.match; e.err = t.err;
        sb.push_back(e);
        #2;
        check_out(tag);
    endtask

    task automatic drive_idle();
        rst                     = 1'b0;
        bus.disp_moitf_ena      = 1'b0;
        bus.disp_oitf_qubitlist = '0;
        bus.disp_oitf_qfren     = 1'b0;
        bus.mres_i_valid        = 1'b0;
        bus.mres_i_qubits       = '0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int  waited;
        bit  done;
        n_checks = 0;
        n_fail   = 0;
        drive_idle();
        rst = 1'b1;
        repeat (2) @(posedge clk);

        //                rst ena list    qf mv mq       rdy emp cnt qflag   m  err
        tbl.push_back(mk(1, 0, 12'h000, 0, 0, 12'h000, 1, 1, 0, 12'h000, 0, 0)); // in reset
        tbl.push_back(mk(0, 0, 12'h000, 0, 0, 12'h000, 1, 1, 0, 12'h000, 0, 0)); // idle
        tbl.push_back(mk(0, 1, 12'h003, 1, 0, 12'h000, 1, 1, 0, 12'h000, 0, 0)); // alloc 003
        tbl.push_back(mk(0, 0, 12'h002, 1, 0, 12'h000, 1, 0, 1, 12'h003, 1, 0)); // hazard
        tbl.push_back(mk(0, 0, 12'h004, 1, 0, 12'h000, 1, 0, 1, 12'h003, 0, 0)); // no hazard
        tbl.push_back(mk(0, 0, 12'h000, 0, 1, 12'h003, 1, 0, 1, 12'h003, 0, 0)); // resolve
        tbl.push_back(mk(0, 0, 12'h000, 0, 0, 12'h000, 1, 1, 0, 12'h000, 0, 0)); // retired
        tbl.push_back(mk(0, 1, 12'h001, 0, 0, 12'h000, 1, 1, 0, 12'h000, 0, 0)); // fill 1
        tbl.push_back(mk(0, 1, 12'h002, 0, 0, 12'h000, 1, 0, 1, 12'h001, 0, 0)); // fill 2
        tbl.push_back(mk(0, 1, 12'h004, 0, 0, 12'h000, 1, 0, 2, 12'h003, 0, 0)); // fill 3
        tbl.push_back(mk(0, 1, 12'h008, 0, 0, 12'h000, 1, 0, 3, 12'h007, 0, 0)); // fill 4
        tbl.push_back(mk(0, 1, 12'h010, 0, 0, 12'h000, 0, 0, 4, 12'h00F, 0, 0)); // 5th ena
        tbl.push_back(mk(0, 0, 12'h000, 0, 1, 12'h001, 0, 0, 4, 12'h00F, 0, 1)); // err, res head
        tbl.push_back(mk(0, 0, 12'h000, 0, 0, 12'h000, 1, 0, 3, 12'h00E, 0, 0)); // slot freed
        tbl.push_back(mk(0, 0, 12'h000, 0, 1, 12'h004, 1, 0, 3, 12'h00E, 0, 0)); // non-head res
        tbl.push_back(mk(0, 0, 12'h000, 0, 0, 12'h000, 1, 0, 3, 12'h00A, 0, 0)); // waits
        tbl.push_back(mk(0, 0, 12'h000, 0, 1, 12'h002, 1, 0, 3, 12'h00A, 0, 0)); // head res
        tbl.push_back(mk(0, 0, 12'h000, 0, 0, 12'h000, 1, 0, 2, 12'h008, 0, 0)); // 2nd retires
        tbl.push_back(mk(0, 0, 12'h000, 0, 0, 12'h000, 1, 0, 1, 12'h008, 0, 0));
        tbl.push_back(mk(0, 1, 12'h020, 0, 1, 12'h008, 1, 0, 1, 12'h008, 0, 0)); // alloc+retire
        tbl.push_back(mk(0, 1, 12'h040, 0, 1, 12'h020, 1, 0, 1, 12'h020, 0, 0));
        tbl.push_back(mk(0, 1, 12'h080, 0, 1, 12'h040, 1, 0, 1, 12'h040, 0, 0));
        tbl.push_back(mk(0, 1, 12'h100, 0, 1, 12'h080, 1, 0, 1, 12'h080, 0, 0)); // 3->0 wrap
        tbl.push_back(mk(0, 0, 12'h100, 0, 0, 12'h000, 1, 0, 1, 12'h100, 0, 0)); // qfren=0
        tbl.push_back(mk(0, 0, 12'h000, 0, 1, 12'h100, 1, 0, 1, 12'h100, 0, 0));
        tbl.push_back(mk(0, 1, 12'h000, 0, 0, 12'h000, 1, 1, 0, 12'h000, 0, 0)); // zero mask
        tbl.push_back(mk(0, 0, 12'h000, 0, 0, 12'h000, 1, 0, 1, 12'h000, 0, 0)); // auto retire
        tbl.push_back(mk(0, 0, 12'h000, 0, 0, 12'h000, 1, 1, 0, 12'h000, 0, 0));
        tbl.push_back(mk(0, 0, 12'h000, 0, 1, 12'h001, 1, 1, 0, 12'h000, 0, 0)); // mres empty
        tbl.push_back(mk(0, 0, 12'h000, 0, 0, 12'h000, 1, 1, 0, 12'h000, 0, 1));
        tbl.push_back(mk(0, 1, 12'h003, 0, 0, 12'h000, 1, 1, 0, 12'h000, 0, 0));
        tbl.push_back(mk(0, 0, 12'h000, 0, 1, 12'h005, 1, 0, 1, 12'h003, 0, 0)); // part illegal
        tbl.push_back(mk(0, 0, 12'h000, 0, 0, 12'h000, 1, 0, 1, 12'h002, 0, 1)); // legal cleared
        tbl.push_back(mk(0, 1, 12'h010, 0, 0, 12'h000, 1, 0, 1, 12'h002, 0, 0));
        tbl.push_back(mk(0, 1, 12'h020, 0, 0, 12'h000, 1, 0, 2, 12'h012, 0, 0));
        tbl.push_back(mk(1, 1, 12'h040, 0, 0, 12'h000, 1, 1, 0, 12'h000, 0, 0)); // reset, 3 pend
        tbl.push_back(mk(0, 0, 12'h000, 0, 0, 12'h000, 1, 1, 0, 12'h000, 0, 0));

        for (int i = 0; i < tbl.size(); i++) begin
            apply(tbl[i], $sformatf("v%0d", i));
        end

        // Full FIFO: the head retires in the same cycle as an extra ena. No bypass, so the
        // ena is still rejected with an error and the count drops to 3.
        apply(mk(0, 1, 12'h001, 0, 0, 12'h000, 1, 1, 0, 12'h000, 0, 0), "h0");
        apply(mk(0, 1, 12'h002, 0, 0, 12'h000, 1, 0, 1, 12'h001, 0, 0), "h1");
        apply(mk(0, 1, 12'h004, 0, 0, 12'h000, 1, 0, 2, 12'h003, 0, 0), "h2");
        apply(mk(0, 1, 12'h008, 0, 0, 12'h000, 1, 0, 3, 12'h007, 0, 0), "h3");
        apply(mk(0, 1, 12'h010, 0, 1, 12'h001, 0, 0, 4, 12'h00F, 0, 0), "h4");
        apply(mk(0, 0, 12'h000, 0, 0, 12'h000, 1, 0, 3, 12'h00E, 0, 1), "h5");

        // Resolve every remaining qubit at once: entries then retire one per cycle.
        @(negedge clk);
        drive_idle();
        bus.mres_i_valid  = 1'b1;
        bus.mres_i_qubits = 12'h00E;
        waited = 0;
        done   = 1'b0;
        for (int k = 0; k < 8 && !done; k++) begin
            @(negedge clk);
            drive_idle();
            #2;
            waited++;
            if (bus.moitf_empty) done = 1'b1;
        end
        chk("drain_done", {11'd0, done}, 12'd1);
        chk("drain_cycles", waited[11:0], 12'd3);
        chk("drain_err", {11'd0, bus.moitf_err}, 12'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule : tb_qpu_exu_moitf
